// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states and default bus geometry used by
// the requester, the completer and the testbench.
package apb_pkg;

    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 8;
    localparam int APB_DEPTH  = 8;
    localparam int APB_WAIT_W = 4;

    typedef enum logic {
        APB_IDLE,
        APB_ACCESS
    } apb_cpl_state_t;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register file: cleared by reset, one synchronous write port,
// one asynchronous read port. Out-of-range addresses never write and read as zero.
module apb_regfile #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  ridx;
    logic              waddr_ok;
    logic              raddr_ok;

    assign widx     = waddr[IDX_W-1:0];
    assign ridx     = raddr[IDX_W-1:0];
    assign waddr_ok = {1'b0, waddr} < DEPTH_C;
    assign raddr_ok = {1'b0, raddr} < DEPTH_C;

    // NOTE: every entry is cleared on reset because the all-zero state is
    // architecturally visible here; a large RAM would not be reset like this.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && waddr_ok) begin
            mem_q[widx] <= wdata;
        end
    end

    // NOTE: rdata gets its default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        rdata = '0;
        if (raddr_ok) begin
            rdata = mem_q[ridx];
        end
    end

endmodule

// File: rtl/apb_completer_regs.sv
// APB3 completer: latches the request in the setup cycle, counts programmable
// wait states, then commits a write or returns read data / PSLVERR.
module apb_completer_regs
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int DEPTH  = APB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [APB_WAIT_W-1:0] wait_cycles,
    output logic                  pready,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pslverr
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    apb_cpl_state_t        state_q, state_d;
    logic [APB_WAIT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  addr_ok;
    logic                  reg_we;
    logic [DATA_W-1:0]     reg_rdata;

    assign addr_ok = {1'b0, addr_q} < DEPTH_C;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        reg_we  = 1'b0;
        case (state_q)
            APB_IDLE: begin
                // Only a proper setup phase starts a transfer; penable without setup is ignored.
                if (psel && !penable) begin
                    state_d = APB_ACCESS;
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    cnt_d   = wait_cycles;
                end
            end
            APB_ACCESS: begin
                if (!psel) begin
                    state_d = APB_IDLE;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - APB_WAIT_W'(1);
                    end else begin
                        state_d = APB_IDLE;
                        reg_we  = write_q && addr_ok;
                    end
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= APB_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    apb_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (reg_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (reg_rdata)
    );

    // Response is decoded from registered state only, never from bus inputs.
    always_comb begin
        pready  = (state_q == APB_ACCESS) && (cnt_q == '0);
        pslverr = pready && !addr_ok;
        prdata  = (pready && !write_q && addr_ok) ? reg_rdata : '0;
    end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Self-checking bench for apb_completer_regs: a driver issues APB transfers and
// queues expected responses; a monitor checks each pready response against them.
module tb_apb_completer_regs;
    import apb_pkg::*;

    localparam int AW    = APB_ADDR_W;
    localparam int DW    = APB_DATA_W;
    localparam int DEPTH = APB_DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    wait_cycles = '0;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    apb_completer_regs dut (
        .clk         (clk),
        .rst         (rst),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .wait_cycles (wait_cycles),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        logic          err;
        int            wt;
        int            start;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model [2**AW];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pready must match the oldest queued expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (pready) begin
            if (sb_q.size() == 0) begin
                check("spurious_pready", 32'(pready), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pslverr", 32'(pslverr), 32'(mon_e.err));
                check("prdata", 32'(prdata), 32'(mon_e.rdata));
                check("xfer_len", 32'(cyc - mon_e.start + 1), 32'(mon_e.wt + 2));
            end
        end else begin
            check("idle_prdata", 32'(prdata), 32'd0);
            check("idle_pslverr", 32'(pslverr), 32'd0);
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
    endtask

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int wt, input bit scramble);
        exp_t e;
        int   n;
        bit   done;
        @(posedge clk); #1;
        psel        = 1'b1;
        penable     = 1'b0;
        pwrite      = w;
        paddr       = a;
        pwdata      = d;
        wait_cycles = 4'(wt);
        e.w     = w;
        e.addr  = a;
        e.err   = (int'(a) >= DEPTH);
        e.rdata = (!w && int'(a) < DEPTH) ? model[a] : '0;
        e.wt    = wt;
        e.start = cyc;
        if (w && int'(a) < DEPTH) model[a] = d;
        sb_q.push_back(e);
        @(posedge clk); #1;
        penable     = 1'b1;
        wait_cycles = 4'($urandom);
        if (scramble) begin
            pwdata = 8'hFF;
            paddr  = a ^ 4'h1;
        end
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            done = pready;
            @(posedge clk); #1;
            n++;
        end
        if (!done) check("xfer_timeout", 32'(done), 32'd1);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic abort_xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input int wt,
                              input int after, input bit use_rst);
        @(posedge clk); #1;
        psel        = 1'b1;
        penable     = 1'b0;
        pwrite      = 1'b1;
        paddr       = a;
        pwdata      = d;
        wait_cycles = 4'(wt);
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < after; i++) begin
            @(negedge clk);
            check("abort_wait_pready", 32'(pready), 32'd0);
            @(posedge clk); #1;
        end
        psel    = 1'b0;
        penable = 1'b0;
        if (use_rst) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
            clear_model();
        end
        @(negedge clk);
        check("abort_after_pready", 32'(pready), 32'd0);
    endtask

    initial begin
        int a, d, wt;
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", 32'(prdata), 32'd0);
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, AW'(i), '0, 0, 1'b0);

        xfer(1'b1, 4'd3, 8'hA5, 0, 1'b0);
        xfer(1'b0, 4'd3, 8'h00, 0, 1'b0);

        xfer(1'b1, 4'd5, 8'h3C, 4, 1'b1);
        xfer(1'b0, 4'd5, 8'h00, 0, 1'b0);

        xfer(1'b1, 4'd9, 8'h11, 2, 1'b0);
        xfer(1'b0, 4'd9, 8'h00, 1, 1'b0);
        xfer(1'b0, 4'd15, 8'h00, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, AW'(i), '0, 0, 1'b0);

        abort_xfer(4'd2, 8'h77, 6, 2, 1'b0);
        xfer(1'b0, 4'd2, 8'h00, 0, 1'b0);
        abort_xfer(4'd2, 8'h77, 6, 2, 1'b1);
        xfer(1'b0, 4'd2, 8'h00, 0, 1'b0);
        xfer(1'b0, 4'd3, 8'h00, 0, 1'b0);

        xfer(1'b1, 4'd7, 8'h5A, 15, 1'b1);
        xfer(1'b0, 4'd7, 8'h00, 15, 1'b0);
        xfer(1'b0, 4'd6, 8'h00, 0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            a  = int'($urandom_range(5, 1));
            d  = int'($urandom_range(9, 1));
            wt = int'($urandom_range(15, 0));
            xfer(1'b1, AW'(a), DW'(d), wt, 1'b0);
            xfer(1'b0, AW'(a), 8'h00, int'($urandom_range(15, 0)), 1'b0);
        end

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
